// File: rtl/ahb_sif_mem_if.sv
// AHB-Lite bus bundle between one 64-bit master and the ahb_sif_mem slave.
// Carries every address/data-phase signal except the clock and reset.
//   master modport : drives HSEL..HREADY, samples HREADYOUT/HRESP/HRDATA
//   slave  modport : the mirror image
interface ahb_sif_mem_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [63:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [63:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_sif_mem.sv
// Behavioral zero-wait-state AHB-Lite slave memory for core-level simulation.
// Byte-addressable array 'mem' (2^MEM_AW bytes, upper HADDR bits alias) plus a
// write-only mailbox address used by test programs for console output.
// Ports:
//   HCLK, HRESET   : clock, synchronous active-high reset
//   ahb (slave)    : AHB-Lite slave side, 64-bit data
//   mailbox_write  : one-cycle pulse after a write to MAILBOX_ADDR
//   write_data     : HWDATA of the most recent write (memory or mailbox)
module ahb_sif_mem #(
  parameter int          MEM_AW       = 16,
  parameter logic [31:0] MAILBOX_ADDR = 32'hD058_0000
) (
  input  logic          HCLK,
  input  logic          HRESET,
  ahb_sif_mem_if.slave  ahb,
  output logic          mailbox_write,
  output logic [63:0]   write_data
);

  // Backing store, preloadable by the enclosing bench.
  logic [7:0] mem [0:(2**MEM_AW)-1];

  // Registered address phase.
  logic        valid_q, valid_d;
  logic        write_q, write_d;
  logic [31:0] addr_q,  addr_d;
  logic [2:0]  size_q,  size_d;

  logic        hreadyout_q;
  logic        mailbox_write_q;
  logic [63:0] write_data_q;

  logic              accept;
  logic              wr_active;
  logic              mbx_hit;
  logic [7:0]        lane_en;
  logic [MEM_AW-4:0] row;
  logic [63:0]       rdata;
  int                lane_lo;
  int                lane_hi;

  assign accept = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];

  // NOTE: combinational blocks use blocking '=' with every output defaulted
  // first, so no latch is inferred when 'accept' is low.
  always_comb begin
    valid_d = accept;
    write_d = write_q;
    addr_d  = addr_q;
    size_d  = size_q;
    if (accept) begin
      write_d = ahb.HWRITE;
      addr_d  = ahb.HADDR;
      size_d  = ahb.HSIZE;
    end
  end

  assign row       = addr_q[MEM_AW-1:3];
  assign wr_active = valid_q & write_q;
  assign mbx_hit   = (addr_q == MAILBOX_ADDR);

  // Lanes base..base+2^size-1; anything past lane 7 simply never matches,
  // so a misaligned transfer is truncated rather than wrapped.
  always_comb begin
    lane_en = '0;
    lane_lo = int'(addr_q[2:0]);
    lane_hi = lane_lo + (1 << size_q);
    for (int k = 0; k < 8; k++) begin
      if (k >= lane_lo && k < lane_hi) lane_en[k] = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      valid_q         <= 1'b0;
      write_q         <= 1'b0;
      addr_q          <= '0;
      size_q          <= '0;
      hreadyout_q     <= 1'b0;
      mailbox_write_q <= 1'b0;
      write_data_q    <= '0;
    end else begin
      valid_q         <= valid_d;
      write_q         <= write_d;
      addr_q          <= addr_d;
      size_q          <= size_d;
      hreadyout_q     <= 1'b1;
      mailbox_write_q <= wr_active & mbx_hit;
      if (wr_active) write_data_q <= ahb.HWDATA;
    end
  end

  // NOTE: the memory array has no reset so preloaded contents survive it;
  // only the write enable is gated, which drops a data phase caught by reset.
  always_ff @(posedge HCLK) begin
    if (!HRESET && wr_active && !mbx_hit) begin
      for (int k = 0; k < 8; k++) begin
        if (lane_en[k]) mem[{row, 3'(k)}] <= ahb.HWDATA[8*k +: 8];
      end
    end
  end

  // All eight lanes of the addressed dword are returned whatever HSIZE was;
  // a write in the previous data phase is already in 'mem' by now.
  always_comb begin
    rdata = '0;
    for (int k = 0; k < 8; k++) rdata[8*k +: 8] = mem[{row, 3'(k)}];
  end

  assign ahb.HRDATA    = (valid_q && !write_q) ? rdata : '0;
  assign ahb.HREADYOUT = hreadyout_q;
  assign ahb.HRESP     = 1'b0;
  assign mailbox_write = mailbox_write_q;
  assign write_data    = write_data_q;

  // Burst type and protection are accepted but have no effect here.
  logic unused_ok;
  assign unused_ok = ^{ahb.HBURST, ahb.HPROT};

endmodule

// File: tb/tb_ahb_sif_mem.sv
// Self-checking bench for ahb_sif_mem. The driver predicts every output for
// the following cycle from a byte-level reference model and queues it; a
// negedge monitor pops and compares once the DUT reaches that cycle.
module tb_ahb_sif_mem;

  localparam logic [31:0] MBX = 32'hD058_0000;

  typedef struct {
    int          due;
    logic [63:0] hrdata;
    logic        mbx;
    logic [63:0] wdata;
    logic        hro;
  } exp_t;

  logic        clk;
  logic        HRESET;
  logic        mailbox_write;
  logic [63:0] write_data;

  ahb_sif_mem_if bus ();

  ahb_sif_mem #(.MEM_AW(16), .MAILBOX_ADDR(MBX)) dut (
    .HCLK          (clk),
    .HRESET        (HRESET),
    .ahb           (bus.slave),
    .mailbox_write (mailbox_write),
    .write_data    (write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t sb[$];

  // Reference model state.
  logic [7:0]  mdl [0:65535];
  logic [63:0] m_wdata = '0;
  logic        p_valid = 1'b0;
  logic        p_write = 1'b0;
  logic [31:0] p_addr  = '0;
  logic [2:0]  p_size  = '0;
  logic [63:0] p_wdata = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_write(input logic [31:0] a, input logic [2:0] sz, input logic [63:0] wd);
    int lane;
    for (int i = 0; i < (1 << sz); i++) begin
      lane = int'(a[2:0]) + i;
      if (lane < 8) mdl[{a[15:3], 3'(lane)}] = wd[8*lane +: 8];
    end
  endtask

  function automatic logic [63:0] model_read(input logic [31:0] a);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = mdl[{a[15:3], 3'(k)}];
    return r;
  endfunction

  // One bus cycle: drive address phase plus HWDATA of the pending write,
  // predict next-cycle outputs, advance to just after the edge.
  task automatic step(input logic rst, input logic sel, input logic [1:0] trans,
                      input logic wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [63:0] wd);
    exp_t e;
    HRESET     = rst;
    bus.HSEL   = sel;
    bus.HTRANS = trans;
    bus.HWRITE = wr;
    bus.HADDR  = a;
    bus.HSIZE  = sz;
    bus.HWDATA = p_wdata;
    e.due    = cyc + 1;
    e.mbx    = 1'b0;
    e.hrdata = '0;
    if (rst) begin
      e.hro   = 1'b0;
      m_wdata = '0;
      p_valid = 1'b0;
    end else begin
      e.hro = 1'b1;
      if (p_valid && p_write) begin
        if (p_addr == MBX) e.mbx = 1'b1;
        else model_write(p_addr, p_size, p_wdata);
        m_wdata = p_wdata;
      end
      p_valid = sel && trans[1];
      if (p_valid && !wr) e.hrdata = model_read(a);
    end
    e.wdata = m_wdata;
    p_write = wr;
    p_addr  = a;
    p_size  = sz;
    p_wdata = wd;
    sb.push_back(e);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 64'h0);
  endtask

  exp_t m;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due == cyc) begin
      m = sb.pop_front();
      check($sformatf("hreadyout@%0d", cyc), 64'(bus.HREADYOUT), 64'(m.hro));
      check($sformatf("hresp@%0d", cyc), 64'(bus.HRESP), 64'h0);
      check($sformatf("hrdata@%0d", cyc), bus.HRDATA, m.hrdata);
      check($sformatf("mbx@%0d", cyc), 64'(mailbox_write), 64'(m.mbx));
      check($sformatf("wdata@%0d", cyc), write_data, m.wdata);
    end
  end

  initial begin
    HRESET     = 1'b1;
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HADDR  = '0;
    bus.HSIZE  = '0;
    bus.HBURST = 3'b000;
    bus.HPROT  = 4'b0011;
    bus.HWDATA = '0;
    bus.HREADY = 1'b1;
    #1;
    // Reset held three cycles, then release.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 64'h0);
    idle();
    // Preload dwords 0x00 and 0x10, then read 0x0.
    step(1'b0, 1'b1, 2'b10, 1'b1, 32'h0,  3'd3, 64'h0706_0504_0302_0100);
    step(1'b0, 1'b1, 2'b10, 1'b1, 32'h10, 3'd3, 64'h8877_6655_4433_2211);
    step(1'b0, 1'b1, 2'b10, 1'b0, 32'h0,  3'd3, 64'h0);
    // Byte write lane 5, read back.
    step(1'b0, 1'b1, 2'b10, 1'b1, 32'h5,  3'd0, 64'h0000_AA00_0000_0000);
    step(1'b0, 1'b1, 2'b10, 1'b0, 32'h0,  3'd3, 64'h0);
    // Word write immediately followed by a read of the same dword.
    step(1'b0, 1'b1, 2'b10, 1'b1, 32'h10, 3'd2, 64'h0000_0000_1234_5678);
    step(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 3'd2, 64'h0);
    // Half write lanes 6-7.
    step(1'b0, 1'b1, 2'b10, 1'b1, 32'h16, 3'd1, 64'hBEEF_0000_0000_0000);
    step(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 3'd3, 64'h0);
    // Mailbox writes, separated by an HSEL=0 and an IDLE write attempt.
    step(1'b0, 1'b1, 2'b10, 1'b1, MBX,    3'd3, 64'h41);
    step(1'b0, 1'b0, 2'b10, 1'b1, 32'h0,  3'd3, 64'h5555_5555_5555_5555);
    step(1'b0, 1'b1, 2'b10, 1'b1, MBX,    3'd3, 64'hFF);
    step(1'b0, 1'b1, 2'b00, 1'b1, 32'h0,  3'd3, 64'h6666_6666_6666_6666);
    idle();
    // Aliased address and mem[0] after mailbox traffic.
    step(1'b0, 1'b1, 2'b10, 1'b0, 32'h0001_0004, 3'd2, 64'h0);
    step(1'b0, 1'b1, 2'b10, 1'b0, 32'h0,  3'd0, 64'h0);
    // Word at lane 6 overflows past lane 7: lanes 6-7 only.
    step(1'b0, 1'b1, 2'b10, 1'b1, 32'h6,  3'd2, 64'hCCDD_EEFF_0000_0000);
    step(1'b0, 1'b1, 2'b10, 1'b0, 32'h0,  3'd3, 64'h0);
    // Write whose data phase collides with reset is discarded.
    step(1'b0, 1'b1, 2'b10, 1'b1, 32'h0,  3'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1'b1, 1'b0, 2'b00, 1'b0, 32'h0,  3'd0, 64'h0);
    idle();
    step(1'b0, 1'b1, 2'b10, 1'b0, 32'h0,  3'd3, 64'h0);
    for (int i = 0; i < 3; i++) idle();
    @(negedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_sif_mem.md
# ahb_sif_mem

Behavioral AHB-Lite slave memory model for core-level simulation. It serves one 64-bit AHB master port: instruction fetch, LSU, or debug system bus. It provides a byte-addressable, preloadable memory with zero-wait-state transfers. It also provides a write-only mailbox address used by test programs for console output and end-of-test signalling.

## Interface
- MEM_AW, 16: byte-address bits decoded into memory (memory size 2^MEM_AW bytes); upper HADDR bits ignored (aliasing).
- MAILBOX_ADDR, 32'hD058_0000: full 32-bit address of the mailbox.
- Clock and reset: one clock; reset is synchronous and active-high.
- HCLK  in  1  clock; all state updates on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HTRANS  in  2  transfer type; HTRANS[1]=1 (NONSEQ/SEQ) means active.
- HWRITE  in  1  1=write, 0=read.
- HSIZE  in  3  0=byte, 1=half, 2=word, 3=dword.
- HBURST  in  3  accepted, ignored.
- HPROT  in  4  accepted, ignored.
- HWDATA  in  64  write data, valid in data phase.
- HREADY  in  1  bus ready (qualifies address phase).
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  response, always OKAY (0).
- HRDATA  out  64  read data.
- mailbox_write  out  1  one-cycle pulse on mailbox write.
- write_data  out  64  last write data captured.

## Operation
- Storage: byte array named mem, index = HADDR[MEM_AW-1:0]. Preloadable by $readmemh, one byte per entry, little-endian. Not cleared by reset.
- Address phase accepted when HSEL & HREADY & HTRANS[1]. Registers: addr, write flag, size, valid.
- Byte lanes: base lane = addr[2:0], count = 1<<size. Lanes base..base+count-1; lanes beyond 7 are dropped (no wrap). Lane k = data bits [8k+7:8k].
- Write data phase: each enabled lane writes HWDATA lane k to mem[{addr[MEM_AW-1:3],k}]. write_data <= HWDATA for every write.
- Mailbox write: when the full 32-bit addr == MAILBOX_ADDR, memory is not updated. mailbox_write <= 1 for exactly one cycle; write_data <= HWDATA.
- Read data phase: HRDATA = the 8 bytes at {addr[MEM_AW-1:3],3'b000}, combinational from the registered address. All lanes are returned regardless of HSIZE. HRDATA = 0 when not in a read data phase.
- IDLE/BUSY or HSEL=0: no access; the pending data phase still completes.
- HRESP tied 0. HBURST and HPROT have no effect.

## Timing
- Reset (HRESET=1 at an edge):
  - Outputs: HREADYOUT=0, HRDATA=0, HRESP=0, mailbox_write=0, write_data=0.
  - Internal: valid=0.
  - A data phase in flight when reset hits is discarded: no memory write.
- First edge after reset release: HREADYOUT=1, held 1 thereafter. Zero wait states.
- Address phase in cycle N → data phase in cycle N+1:
  - Write: mem updated at end of N+1.
  - Read: HRDATA valid during N+1.
- Back-to-back write then read of the same address (write data phase N+1, read address phase N+1): the read data in N+2 reflects the new bytes.
- Pipelining: a new address phase may be accepted in the same cycle as the previous data phase.
- mailbox_write is high in cycle N+2 for a mailbox write addressed in N. write_data is updated at the same edge and held until the next write.

## Test plan
- Reset: hold HRESET 3 cycles → HREADYOUT=0, HRDATA=0, mailbox_write=0. After release, HREADYOUT=1 at the next edge.
- Preload via mem: bytes 0..7 = 0x00..0x07. Read dword at 0x0 (HSIZE=3) → HRDATA=64'h0706050403020100 in the data-phase cycle.
- Byte write: HADDR=0x5, HSIZE=0, HWDATA=64'h0000_AA00_0000_0000, then read 0x0 → HRDATA=64'h0706AA0403020100. Other bytes unchanged.
- Pipelined traffic:
  - Word write 0x1234_5678 at 0x10 (lanes 0-3), immediately followed by a read of 0x10 → HRDATA[31:0]=0x12345678 the next cycle.
  - Half write at 0x16 (lanes 6-7) → only bytes 0x16-0x17 change.
- Mailbox: write HWDATA=64'h41 to 0xD058_0000 → mailbox_write=1 for exactly one cycle, write_data[7:0]=0x41, mem[0] unchanged. Repeat with 0xFF → write_data[7:0]=0xFF.
- Aliasing/idle: access 0x0001_0004 with MEM_AW=16 → hits mem[4]. HTRANS=IDLE or HSEL=0 cycles → no memory change, HRDATA=0.
